// File: rtl/event_serializer.sv
// Event serializer: buffers parallel DVS events in a small FIFO and streams each
// one as a 5-byte frame (header, x, y, t, checksum) on a valid/ready byte port.
module event_serializer #(
    parameter int         DEPTH   = 4,
    parameter logic [3:0] HDR_TAG = 4'hA
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ev_valid,
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic [7:0] t,
    input  logic       p,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic       drop_clr,
    output logic [7:0] drop_cnt,
    output logic       busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_BX,
        S_BY,
        S_BT,
        S_CHK
    } state_t;

    state_t state_reg, state_next;

    logic [24:0]   fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [24:0]   frame_reg;
    logic [7:0]    drop_cnt_reg;

    logic fifo_empty, fifo_full;
    logic pop, push, drop;

    logic       f_p;
    logic [7:0] f_x, f_y, f_t;
    logic [7:0] hdr_byte, chk_byte;

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == FULL_COUNT);

    // A pop either starts a frame from idle or chains the next frame onto an
    // accepted checksum byte, so a full FIFO can still take a push that cycle.
    assign pop  = ~fifo_empty & ((state_reg == S_IDLE) | ((state_reg == S_CHK) & tx_ready));
    assign push = ev_valid & (~fifo_full | pop);
    assign drop = ev_valid & ~push;

    assign f_p = frame_reg[24];
    assign f_x = frame_reg[23:16];
    assign f_y = frame_reg[15:8];
    assign f_t = frame_reg[7:0];

    assign hdr_byte = {HDR_TAG, 3'b000, f_p};
    assign chk_byte = hdr_byte ^ f_x ^ f_y ^ f_t;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (!fifo_empty) state_next = S_HDR;
            S_HDR:  if (tx_ready) state_next = S_BX;
            S_BX:   if (tx_ready) state_next = S_BY;
            S_BY:   if (tx_ready) state_next = S_BT;
            S_BT:   if (tx_ready) state_next = S_CHK;
            S_CHK:  if (tx_ready) state_next = fifo_empty ? S_IDLE : S_HDR;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        case (state_reg)
            S_HDR: tx_data = hdr_byte;
            S_BX:  tx_data = f_x;
            S_BY:  tx_data = f_y;
            S_BT:  tx_data = f_t;
            S_CHK: tx_data = chk_byte;
            default: tx_valid = 1'b0;
        endcase
    end

    assign busy     = tx_valid | ~fifo_empty;
    assign drop_cnt = drop_cnt_reg;

    // Storage carries no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {p, x, y, t};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            frame_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                frame_reg  <= fifo_mem[rd_ptr_reg];
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // A clear coinciding with a drop leaves that drop counted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt_reg <= 8'h00;
        end else if (drop_clr) begin
            drop_cnt_reg <= {7'b0, drop};
        end else if (drop && (drop_cnt_reg != 8'hFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 1'b1;
        end
    end

endmodule
